// File: rtl/datapath_unit.sv
// datapath_unit: two-stage pipelined ALU + 2^ADDR_BITS-word data memory.
//
// Stage 1 (edge N):   alu_q <= ALU(A,B), rdata_q <= mem[addr] (old word on a
//                     same-edge write), sel1_q <= sel1, optional write.
// Stage 2 (edge N+1): result2 <= sel1_q ? alu_q : rdata_q.
//
// Ports:
//   clk       single clock, rising edge
//   rst       asynchronous active-low reset (clears pipeline and memory)
//   operand1  ALU A input / memory base address
//   operand2  ALU B input / memory write data
//   offset    memory address offset / alternate ALU B input
//   opcode    ALU operation select (1111 = NOP, alu_q holds)
//   sel1      result source: 1 = ALU, 0 = data memory
//   sel3      ALU B select: 1 = offset, 0 = operand2
//   w_r       data-memory write enable
//   result2   registered result
//   flags     {carry, zero}, only when DATAPATH_FLAGS_EN is defined
//
// Optional feature macro: DATAPATH_FLAGS_EN
module datapath_unit #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_BITS  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] offset,
  input  logic [3:0]            opcode,
  input  logic                  sel1,
  input  logic                  sel3,
  input  logic                  w_r,
`ifdef DATAPATH_FLAGS_EN
  output logic [1:0]            flags,
`endif
  output logic [DATA_WIDTH-1:0] result2
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_BITS-1:0]  addr;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_res;
  logic [DATA_WIDTH-1:0] alu_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  sel1_q;
  logic                  nop;

  // Carries above ADDR_BITS are dropped so the address wraps.
  assign addr  = ADDR_BITS'(operand1 + offset);
  assign alu_b = sel3 ? offset : operand2;
  assign nop   = (opcode == 4'b1111);

  always_comb begin
    alu_res = '0;
    case (opcode)
      4'b0000: alu_res = operand1 + alu_b;
      4'b0001: alu_res = operand1 - alu_b;
      4'b0010: alu_res = operand1 & alu_b;
      4'b0011: alu_res = operand1 | alu_b;
      4'b0100: alu_res = operand1 ^ alu_b;
      4'b0101: alu_res = ~operand1;
      4'b0110: alu_res = operand1 << 1;
      4'b0111: alu_res = operand1 >> 1;
      4'b1000: alu_res = operand1;
      4'b1001: alu_res = alu_b;
      4'b1010: alu_res = operand1 + DATA_WIDTH'(1);
      4'b1011: alu_res = operand1 - DATA_WIDTH'(1);
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q   <= '0;
      rdata_q <= '0;
      sel1_q  <= 1'b0;
      result2 <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[ADDR_BITS'(i)] <= '0;
      end
    end else begin
      if (!nop) begin
        alu_q <= alu_res;
      end
      // Non-blocking read of mem gives the pre-write word on a collision.
      rdata_q <= mem[addr];
      sel1_q  <= sel1;
      result2 <= sel1_q ? alu_q : rdata_q;
      if (w_r) begin
        mem[addr] <= operand2;
      end
    end
  end

`ifdef DATAPATH_FLAGS_EN
  logic       carry;
  logic [1:0] flags_q;

  // Carry derived by comparison on the truncated result: A+B wrapped iff the
  // sum is below A; borrow on A-B iff A < B.
  always_comb begin
    carry = 1'b0;
    case (opcode)
      4'b0000: carry = (alu_res < operand1);
      4'b0001: carry = (operand1 < alu_b);
      4'b0110: carry = operand1[DATA_WIDTH-1];
      4'b0111: carry = operand1[0];
      4'b1010: carry = (operand1 == '1);
      4'b1011: carry = (operand1 == '0);
      default: carry = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= 2'b00;
      flags   <= 2'b00;
    end else begin
      if (!nop) begin
        flags_q <= {carry, (alu_res == '0)};
      end
      flags <= flags_q;
    end
  end
`endif

endmodule

// File: tb/tb_datapath_unit.sv
// Directed self-checking bench for datapath_unit (DATA_WIDTH=8, ADDR_BITS=5).
module tb_datapath_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] operand1, operand2, offset;
  logic [3:0] opcode;
  logic       sel1, sel3, w_r;
  logic [7:0] result2;
`ifdef DATAPATH_FLAGS_EN
  logic [1:0] flags;
`endif

  int checks = 0;
  int errors = 0;

  datapath_unit #(.DATA_WIDTH(8), .ADDR_BITS(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .offset   (offset),
    .opcode   (opcode),
    .sel1     (sel1),
    .sel3     (sel3),
    .w_r      (w_r),
`ifdef DATAPATH_FLAGS_EN
    .flags    (flags),
`endif
    .result2  (result2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one operation, clock it in, then settle just past the edge.
  task automatic op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] off,
                    input logic [3:0] opc, input logic s1, input logic s3, input logic wr);
    operand1 = a; operand2 = b; offset = off; opcode = opc;
    sel1 = s1; sel3 = s3; w_r = wr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    op(8'h00, 8'h00, 8'h00, 4'b1000, 1'b1, 1'b0, 1'b0);
  endtask

  typedef struct {
    logic [7:0] a, b, off;
    logic [3:0] opc;
    logic       s3;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vecs[0]  = '{8'd10,  8'd20,  8'h00, 4'b0001, 1'b0, 8'hF6};
    vecs[1]  = '{8'h5A,  8'h00,  8'h00, 4'b0101, 1'b0, 8'hA5};
    vecs[2]  = '{8'h81,  8'h00,  8'h00, 4'b0110, 1'b0, 8'h02};
    vecs[3]  = '{8'h81,  8'h00,  8'h00, 4'b0111, 1'b0, 8'h40};
    vecs[4]  = '{8'h7E,  8'h11,  8'h00, 4'b1000, 1'b0, 8'h7E};
    vecs[5]  = '{8'h01,  8'h3C,  8'h00, 4'b1001, 1'b0, 8'h3C};
    vecs[6]  = '{8'h01,  8'h3C,  8'h99, 4'b1001, 1'b1, 8'h99};
    vecs[7]  = '{8'hFF,  8'h00,  8'h00, 4'b1010, 1'b0, 8'h00};
    vecs[8]  = '{8'h10,  8'h77,  8'h05, 4'b0000, 1'b1, 8'h15};
    vecs[9]  = '{8'hFF,  8'hFF,  8'h00, 4'b1100, 1'b0, 8'h00};
    vecs[10] = '{8'hFF,  8'hFF,  8'h00, 4'b1110, 1'b0, 8'h00};

    rst = 1'b0;
    operand1 = '0; operand2 = '0; offset = '0; opcode = '0;
    sel1 = 1'b0; sel3 = 1'b0; w_r = 1'b0;
    #2;
    check("reset_result2", result2, 8'h00);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // 200 + 100 wraps to 44
    op(8'd200, 8'd100, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    idle();
    check("add_wrap", result2, 8'd44);
`ifdef DATAPATH_FLAGS_EN
    check("add_flags", {6'b0, flags}, 8'h02);
`endif

    // store A5 at (30+5) mod 32 = 3, read back via both address forms
    op(8'd30, 8'hA5, 8'd5, 4'b0000, 1'b0, 1'b0, 1'b1);
    op(8'd30, 8'h00, 8'd5, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("store_old_word", result2, 8'h00);
    op(8'd3, 8'h00, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("load_30_5", result2, 8'hA5);
    idle();
    check("load_wrap_3", result2, 8'hA5);

    // read-before-write collision on addr 4
    op(8'd4, 8'h11, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
    op(8'd4, 8'h22, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("pre_collision", result2, 8'h00);
    op(8'd4, 8'h00, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("collision_old", result2, 8'h11);
    idle();
    check("collision_new", result2, 8'h22);

    // back-to-back logic ops
    op(8'hF0, 8'h3C, 8'h00, 4'b0010, 1'b1, 1'b0, 1'b0);
    op(8'hF0, 8'h3C, 8'h00, 4'b0011, 1'b1, 1'b0, 1'b0);
    check("b2b_and", result2, 8'h30);
    op(8'hF0, 8'h3C, 8'h00, 4'b0100, 1'b1, 1'b0, 1'b0);
    check("b2b_or", result2, 8'hFC);
    idle();
    check("b2b_xor", result2, 8'hCC);

    // streamed ALU table: each result checked one op later
    for (int i = 0; i < 11; i++) begin
      op(vecs[i].a, vecs[i].b, vecs[i].off, vecs[i].opc, 1'b1, vecs[i].s3, 1'b0);
      if (i > 0) check($sformatf("alu_vec%0d", i - 1), result2, vecs[i - 1].exp);
    end
    idle();
    check("alu_vec10", result2, vecs[10].exp);

    // NOP holds alu_q; undefined opcode yields 0
    op(8'd0, 8'h00, 8'h00, 4'b1011, 1'b1, 1'b0, 1'b0);
    op(8'd5, 8'h00, 8'h00, 4'b1111, 1'b1, 1'b0, 1'b0);
    check("dec_zero", result2, 8'hFF);
    op(8'd6, 8'h00, 8'h00, 4'b1111, 1'b1, 1'b0, 1'b0);
    check("nop_hold1", result2, 8'hFF);
    op(8'd7, 8'h00, 8'h00, 4'b1101, 1'b1, 1'b0, 1'b0);
    check("nop_hold2", result2, 8'hFF);
    idle();
    check("undef_zero", result2, 8'h00);

    // mid-stream reset with write attempts to addr 3 while held
    op(8'd200, 8'd100, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    op(8'd1, 8'd1, 8'h00, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("pre_reset", result2, 8'd44);
    operand1 = 8'd3; operand2 = 8'h77; offset = 8'd0; w_r = 1'b1; sel1 = 1'b1;
    rst = 1'b0;
    #1;
    check("async_reset", result2, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_held", result2, 8'h00);
    rst = 1'b1;
    op(8'd3, 8'h00, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    op(8'd4, 8'h00, 8'd0, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("mem3_cleared", result2, 8'h00);
    idle();
    check("mem4_cleared", result2, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
